// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, default depth, stage names, start-slot decode.
// No logic here; constants and a constant function only.
// No flow control; consumed at elaboration time.
package pipe_pkg;

  localparam int XLEN           = 32;
  localparam int NSTAGE_DEFAULT = 5;
  // Upper bound on channels, sizes the START_VEC argument of start_of().
  localparam int MAX_CHAN       = 32;

  // Named slots of the core pipeline, youngest first.
  typedef enum int {
    ST_ID  = 0,
    ST_EX  = 1,
    ST_MEM = 2,
    ST_WB  = 3
  } stage_e;

  // Entry slot of channel c from a packed byte-per-channel vector.
  function automatic int start_of(input logic [MAX_CHAN*8-1:0] vec, input int c);
    return int'(vec[8*c +: 8]);
  endfunction

endpackage

// File: rtl/pipe_sideband_buf_if.sv
// Bundle of hazard-unit controls, datapath inputs and slot outputs for the side-band buffer.
// No latency of its own; pure wiring.
// No backpressure: the buffer has no output handshake.
interface pipe_sideband_buf_if
  import pipe_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEFAULT,
  parameter int NCHAN  = 1,
  parameter int DW     = XLEN
);

  logic [NSTAGE-1:0]                    stall;
  logic [NSTAGE-1:0]                    flush;
  logic [NCHAN-1:0][DW-1:0]             in_data;
  logic [NCHAN-1:0]                     in_valid;
  logic [NSTAGE-1:0][NCHAN-1:0]         upd_en;
  logic [NSTAGE-1:0][NCHAN-1:0][DW-1:0] upd_data;
  logic [NCHAN-1:0][NSTAGE-1:0][DW-1:0] stream;
  logic [NCHAN-1:0][NSTAGE-1:0]         stream_valid;

  // Pipeline control / datapath side.
  modport master (
    output stall, flush, in_data, in_valid, upd_en, upd_data,
    input  stream, stream_valid
  );

  // The buffer itself.
  modport slave (
    input  stall, flush, in_data, in_valid, upd_en, upd_data,
    output stream, stream_valid
  );

endinterface

// File: rtl/pipe_slot.sv
// One channel/slot register with valid bit; flush > stall > load/bubble priority.
// Latency: one clk edge from source to data/valid.
// Stall holds the slot (a late update is still captured); no other backpressure.
module pipe_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          grst_n,
  input  logic          flush,
  input  logic          stall,
  input  logic          load_src_sel,
  input  logic [DW-1:0] src_data,
  input  logic          src_valid,
  input  logic          upd_en,
  input  logic [DW-1:0] upd_data,
  output logic [DW-1:0] data,
  output logic          valid
);

  // Slot register: flush clears, stall holds (taking a late update), otherwise load or bubble.
  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (stall) begin
      if (upd_en && valid) begin
        data <= upd_data;
      end
    end else if (load_src_sel) begin
      data  <= src_data;
      valid <= src_valid;
    end else begin
      data  <= '0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_sideband_buf.sv
// Per-channel side-band shift buffer riding alongside the core pipeline, with late-update ports.
// Latency: in_data visible at the channel's start slot one edge after capture, +1 slot per free edge.
// Stall holds a slot and bubbles the next; flush clears; oldest slot drops its content, no output handshake.
module pipe_sideband_buf
  import pipe_pkg::*;
#(
  parameter int                 NSTAGE    = NSTAGE_DEFAULT,
  parameter int                 NCHAN     = 1,
  parameter int                 DW        = XLEN,
  parameter logic [NCHAN*8-1:0] START_VEC = '0
) (
  input logic                clk,
  input logic                grst_n,
  pipe_sideband_buf_if.slave sb
);

  localparam logic [MAX_CHAN*8-1:0] START_EXT = (MAX_CHAN*8)'(START_VEC);

  logic [NCHAN-1:0][NSTAGE-1:0][DW-1:0] data_q;
  logic [NCHAN-1:0][NSTAGE-1:0]         valid_q;
  // Value a slot hands downstream: its contents, replaced by a late update when the slot is valid.
  logic [NCHAN-1:0][NSTAGE-1:0][DW-1:0] eff;

  if (NCHAN > MAX_CHAN) begin : g_chk_nchan
    $fatal(1, "pipe_sideband_buf: NCHAN exceeds MAX_CHAN");
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    localparam int ST = start_of(START_EXT, c);

    if (ST >= NSTAGE) begin : g_chk_start
      $fatal(1, "pipe_sideband_buf: channel start slot out of range");
    end

    for (genvar s = 0; s < NSTAGE; s++) begin : g_slot
      if (s < ST) begin : g_absent
        // Slot does not exist for this channel: constant zero, no storage.
        assign data_q[c][s]  = '0;
        assign valid_q[c][s] = 1'b0;
        assign eff[c][s]     = '0;
      end else begin : g_present
        logic          load_src_sel;
        logic [DW-1:0] src_data;
        logic          src_valid;

        assign eff[c][s] = (sb.upd_en[s][c] && valid_q[c][s]) ? sb.upd_data[s][c] : data_q[c][s];

        if (s == ST) begin : g_entry
          // Entry slot loads straight from the datapath input.
          assign load_src_sel = 1'b1;
          assign src_data     = sb.in_data[c];
          assign src_valid    = sb.in_valid[c];
        end else begin : g_follow
          // A held or flushed upstream slot hands down a bubble; flush kills the older copy.
          assign load_src_sel = !(sb.stall[s-1] || sb.flush[s-1]);
          assign src_data     = eff[c][s-1];
          assign src_valid    = valid_q[c][s-1];
        end

        pipe_slot #(.DW(DW)) u_slot (
          .clk          (clk),
          .grst_n       (grst_n),
          .flush        (sb.flush[s]),
          .stall        (sb.stall[s]),
          .load_src_sel (load_src_sel),
          .src_data     (src_data),
          .src_valid    (src_valid),
          .upd_en       (sb.upd_en[s][c]),
          .upd_data     (sb.upd_data[s][c]),
          .data         (data_q[c][s]),
          .valid        (valid_q[c][s])
        );
      end
    end
  end

  assign sb.stream       = data_q;
  assign sb.stream_valid = valid_q;

  // Update ports of absent slots and the oldest slot's outgoing value have no consumer.
  logic unused_sink;
  assign unused_sink = ^{sb.upd_en, sb.upd_data, eff};

endmodule

// File: tb/tb_pipe_sideband_buf.sv
// Bench for pipe_sideband_buf: table of stepped vectors, hand-written reset sequences, and a
// queue scoreboard that follows values from entry to the oldest slot.
// Configuration: NSTAGE=5, NCHAN=2, DW=32, ch0 enters slot 0, ch1 enters slot 2.
module tb_pipe_sideband_buf;
  import pipe_pkg::*;

  localparam int NS = 5;
  localparam int NC = 2;
  localparam int W  = 32;
  localparam logic [NC*8-1:0]  SVEC = 16'h0200;
  localparam logic [NS*NC-1:0] U21  = (NS*NC)'(1) << (2*NC + 1);

  logic clk    = 1'b0;
  logic grst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_sideband_buf_if #(.NSTAGE(NS), .NCHAN(NC), .DW(W)) bus ();

  pipe_sideband_buf #(
    .NSTAGE    (NS),
    .NCHAN     (NC),
    .DW        (W),
    .START_VEC (SVEC)
  ) dut (
    .clk    (clk),
    .grst_n (grst_n),
    .sb     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    bit              adv;
    logic [NS-1:0]   stall;
    logic [NS-1:0]   flush;
    logic [W-1:0]    d0;
    logic            v0;
    logic [W-1:0]    d1;
    logic            v1;
    logic [NS*NC-1:0] upd;
    logic [W-1:0]    ud;
    int              ch;
    int              sl;
    logic [W-1:0]    ed;
    logic            ev;
  } vec_t;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } sb_t;

  vec_t vecs[$];
  sb_t  q0[$];
  sb_t  q1[$];

  task automatic step(input logic [NS-1:0] st, input logic [NS-1:0] fl,
                      input logic [W-1:0] d0, input logic v0,
                      input logic [W-1:0] d1, input logic v1,
                      input logic [NS*NC-1:0] upd, input logic [W-1:0] ud);
    vec_t v;
    v.adv = 1'b1; v.stall = st; v.flush = fl;
    v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1;
    v.upd = upd; v.ud = ud;
    v.ch = 0; v.sl = 0; v.ed = '0; v.ev = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic ex(input int ch, input int sl, input logic [W-1:0] ed, input logic ev);
    vec_t v;
    v.adv = 1'b0; v.stall = '0; v.flush = '0;
    v.d0 = '0; v.v0 = 1'b0; v.d1 = '0; v.v1 = 1'b0;
    v.upd = '0; v.ud = '0;
    v.ch = ch; v.sl = sl; v.ed = ed; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [NS-1:0] st, input logic [NS-1:0] fl,
                       input logic [W-1:0] d0, input logic v0,
                       input logic [W-1:0] d1, input logic v1,
                       input logic [NS*NC-1:0] upd, input logic [W-1:0] ud);
    bus.stall       = st;
    bus.flush       = fl;
    bus.in_data[0]  = d0;
    bus.in_valid[0] = v0;
    bus.in_data[1]  = d1;
    bus.in_valid[1] = v1;
    bus.upd_en      = upd;
    bus.upd_data    = {(NS*NC){ud}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] slot_of(input int ch, input int sl);
    return {bus.stream_valid[ch][sl], bus.stream[ch][sl]};
  endfunction

  task automatic cmp(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%0b data=0x%0h, want valid=%0b data=0x%0h",
               name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic cmp_all_zero(input string tag);
    for (int c = 0; c < NC; c++) begin
      for (int s = 0; s < NS; s++) begin
        cmp($sformatf("%s_c%0d_s%0d", tag, c, s), slot_of(c, s), '0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive('0, '0, '0, 1'b0, '0, 1'b0, '0, '0);

    // Shift: three entries into ch0, ch1 slots below its start stay empty.
    step(0, 0, 32'h1000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h1004, 1, 0, 0, 0, 0);
    step(0, 0, 32'h1008, 1, 0, 0, 0, 0);
    ex(0, 0, 32'h1008, 1); ex(0, 1, 32'h1004, 1); ex(0, 2, 32'h1000, 1);
    ex(0, 3, 0, 0);        ex(0, 4, 0, 0);
    ex(1, 0, 0, 0);        ex(1, 1, 0, 0);        ex(1, 2, 0, 0);

    // Bubble: slot 1 = 0x1000, slot 2 = 0x2000, then stall[1] for one edge.
    step(0, 0, 32'h2000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h1000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h3000, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h1000, 1); ex(0, 2, 32'h2000, 1);
    step(5'b00010, 0, 32'h4000, 1, 0, 0, 0, 0);
    ex(0, 0, 32'h4000, 1); ex(0, 1, 32'h1000, 1); ex(0, 2, 0, 0);
    ex(0, 3, 32'h2000, 1); ex(0, 4, 32'h1008, 1);

    // Flush under stall on slot 2 holding 0xABCD.
    step(0, 0, 32'hABCD, 1, 0, 0, 0, 0);
    step(0, 0, 32'h5000, 1, 0, 0, 0, 0);
    step(0, 0, 32'h6000, 1, 0, 0, 0, 0);
    ex(0, 2, 32'hABCD, 1);
    step(5'b00100, 5'b00100, 32'h7000, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h6000, 1); ex(0, 2, 0, 0); ex(0, 3, 0, 0); ex(0, 4, 32'h4000, 1);

    // flush[1] on an advancing edge: slot 2 gets a bubble, not slot 1's old value.
    step(0, 0, 32'h8000, 1, 0, 0, 0, 0);
    ex(0, 1, 32'h7000, 1); ex(0, 2, 32'h6000, 1);
    step(0, 5'b00010, 32'h9000, 1, 0, 0, 0, 0);
    ex(0, 0, 32'h9000, 1); ex(0, 1, 0, 0); ex(0, 2, 0, 0); ex(0, 3, 32'h6000, 1);

    // Late update on ch1 slot 2, advancing and then stalled.
    step(0, 0, 0, 0, 32'h5, 1, 0, 0);
    ex(1, 2, 32'h5, 1);
    step(0, 0, 0, 0, 32'h6, 1, U21, 32'h77);
    ex(1, 3, 32'h77, 1); ex(1, 2, 32'h6, 1);
    step(5'b00100, 0, 0, 0, 32'h9, 1, U21, 32'h77);
    ex(1, 2, 32'h77, 1); ex(1, 3, 0, 0); ex(1, 4, 32'h77, 1);
    step(0, 0, 0, 0, 32'hA, 1, 0, 0);
    ex(1, 2, 32'hA, 1); ex(1, 3, 32'h77, 1); ex(1, 4, 0, 0);

    // Update aimed at a bubble is ignored.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    ex(1, 2, 0, 0); ex(1, 3, 32'hA, 1);
    step(0, 0, 0, 0, 0, 0, U21, 32'h55);
    ex(1, 3, 0, 0); ex(1, 4, 32'hA, 1);

    // Flush beats both stall and a late update on the same slot.
    step(0, 0, 0, 0, 32'hB, 1, 0, 0);
    ex(1, 2, 32'hB, 1);
    step(5'b00100, 5'b00100, 0, 0, 0, 0, U21, 32'h99);
    ex(1, 2, 0, 0); ex(1, 3, 0, 0);

    // Reset state, held with the clock running.
    #12;
    cmp_all_zero("reset");
    @(negedge clk);
    grst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].adv) begin
        drive(vecs[i].stall, vecs[i].flush, vecs[i].d0, vecs[i].v0,
              vecs[i].d1, vecs[i].v1, vecs[i].upd, vecs[i].ud);
        tick();
      end else begin
        cmp($sformatf("vec%0d_c%0d_s%0d", i, vecs[i].ch, vecs[i].sl),
            slot_of(vecs[i].ch, vecs[i].sl), {vecs[i].ev, vecs[i].ed});
      end
    end
    drive('0, '0, '0, 1'b0, '0, 1'b0, '0, '0);

    // Async reset mid-stream: fill, then drop grst_n between edges.
    drive('0, '0, 32'h1111, 1'b1, 32'h2222, 1'b1, '0, '0);
    tick();
    cmp("prefill_c0s0", slot_of(0, 0), {1'b1, 32'h1111});
    cmp("prefill_c1s2", slot_of(1, 2), {1'b1, 32'h2222});
    @(negedge clk);
    #1 grst_n = 1'b0;
    #1;
    cmp_all_zero("midrst");
    @(negedge clk);
    grst_n = 1'b1;
    drive('0, '0, 32'hC0, 1'b1, 32'hC1, 1'b1, '0, '0);
    tick();
    cmp("refill_c0s0", slot_of(0, 0), {1'b1, 32'hC0});
    cmp("refill_c0s1", slot_of(0, 1), '0);
    cmp("refill_c1s2", slot_of(1, 2), {1'b1, 32'hC1});
    cmp("refill_c1s3", slot_of(1, 3), '0);
    drive('0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    tick();
    cmp("refill_adv_c0s1", slot_of(0, 1), {1'b1, 32'hC0});
    cmp("refill_adv_c1s3", slot_of(1, 3), {1'b1, 32'hC1});

    // Scoreboard: free-running random traffic, values must emerge in order at the oldest slot.
    for (int n = 0; n < 40; n++) begin
      sb_t e0;
      sb_t e1;
      e0.d = $urandom;
      e0.v = 1'($urandom_range(0, 1));
      e1.d = $urandom;
      e1.v = 1'($urandom_range(0, 1));
      drive('0, '0, e0.d, e0.v, e1.d, e1.v, '0, '0);
      q0.push_back(e0);
      q1.push_back(e1);
      tick();
      if (q0.size() == NS) begin
        sb_t x;
        x = q0.pop_front();
        cmp($sformatf("sb_c0_n%0d", n), slot_of(0, NS-1), {x.v, x.d});
      end
      if (q1.size() == NS - 2) begin
        sb_t x;
        x = q1.pop_front();
        cmp($sformatf("sb_c1_n%0d", n), slot_of(1, NS-1), {x.v, x.d});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_sideband_buf.md
Name: pipe_sideband_buf

Overview:
- Generalised per-channel side-band shift buffer that travels alongside the core pipeline, e.g. PC, immediate or CSR data.
- Depth (stage count), channel count and data width are all parameters; each channel enters at its own start stage.
- Each stage has a stall and a flush. A valid bit travels with every slot. A bubble is inserted when an upstream stage holds and the downstream stage advances.
- New over the previous generation: per-stage late-update ports, so a stage can overwrite a channel's value in flight (e.g. an EX result). Sits between the hazard unit (stall/flush) and the datapath stages.

Parameters:
- NSTAGE, 5, number of pipeline register slots; slot 0 is youngest, slot NSTAGE-1 oldest.
- NCHAN, 1, number of independent channels.
- DW, XLEN, data width per channel.
- START_VEC, '0, NCHAN*8 bits; bits [8c+7:8c] give channel c's entry slot. Each entry must be < NSTAGE; elaboration $fatal otherwise.

Ports:
- clk  in  1  clock.
- grst_n  in  1  reset: asynchronous, active-low.
- stall  in  NSTAGE  stall[s]=1: slot s holds.
- flush  in  NSTAGE  flush[s]=1: slot s is cleared on the next edge.
- in_data  in  NCHAN x DW  new value for channel c, captured into slot start[c].
- in_valid  in  NCHAN  validity of in_data[c].
- upd_en  in  NSTAGE x NCHAN  overwrite request for channel c at slot s.
- upd_data  in  NSTAGE x NCHAN x DW  overwrite value.
- stream  out  NCHAN x NSTAGE x DW  registered slot contents.
- stream_valid  out  NCHAN x NSTAGE  registered slot valid bits.

Behaviour:
- Slots s < start[c] do not exist. Their stream is 0 and stream_valid is 0 permanently. They must not synthesise flops.
- Reset (async, grst_n=0): every stream=0 and every stream_valid=0, immediately, regardless of clk. Reset mid-operation discards all contents.
- Effective outgoing value of slot s, channel c:
  - eff = upd_data[s][c] if upd_en[s][c] && stream_valid[c][s]; otherwise stream[c][s].
  - upd_en on an invalid slot is ignored; bubbles stay bubbles.
- Per slot s ≥ start[c], on posedge clk, first matching rule wins:
  1. flush[s]: data=0, valid=0. This applies even if stall[s]=1.
  2. stall[s]: hold, but data takes eff(s). A late update is captured, not lost; valid is unchanged.
  3. s == start[c]: data=in_data[c], valid=in_valid[c].
  4. stall[s-1] or flush[s-1]: bubble, data=0, valid=0. flush[s-1] kills the older copy, so the value does not escape.
  5. otherwise: data=eff(s-1), valid=stream_valid[c][s-1].
- Latency: in_data at edge t appears at stream[c][start] after edge t. It moves one slot per non-stalled edge.
- Channels are fully independent; stall and flush are shared across channels.
- The oldest slot drops its contents when it advances. There is no output handshake.
- Simultaneous events:
  - upd_en at slot s while s+1 advances: s+1 receives upd_data, and slot s itself takes new content per the rules above.
  - flush[s] together with upd_en[s]: flush wins.
- Pure flops plus muxes. No $display or other simulation side effects in synthesisable code.

Decomposition:
- Shared package pipe_pkg: XLEN, default NSTAGE, named stage constants (ST_ID=0, ST_EX=1, ST_MEM=2, ST_WB=3, ...), and the helper function start_of(START_VEC, c).
- One sub-module, pipe_slot: a single channel/slot register with valid. Its inputs are flush, stall, load_src_sel, src_data, src_valid, upd_en, upd_data, and it outputs data and valid. It is instantiated NCHAN x (NSTAGE - start) times under generate.

Test Plan:
Configuration for all scenarios: NSTAGE=5, NCHAN=2, DW=32, start = {ch0: 0, ch1: 2}.
1. Reset and shift: reset, then in_data0 = 0x1000, 0x1004, 0x1008 with valid=1 on three edges, no stall. Required: stream[0] = {0x1008, 0x1004, 0x1000, 0, 0}, all three valid. ch1 slots 0–1 stay 0.
2. Bubble: ch0 holds 0x1000 at slot 1, 0x2000 at slot 2; assert stall[1] for one edge. Required: slot 1 holds 0x1000, slot 2 becomes 0 / valid 0, slot 3 = 0x2000.
3. Flush under stall: stall[2]=1 and flush[2]=1 with slot 2 = 0xABCD. Required: slot 2 = 0 / valid 0. Separately, flush[1] on an advancing edge: slot 2 receives a bubble, not slot 1's old value.
4. Late update: ch1 slot 2 = 0x5 valid; upd_en[2][1]=1, upd_data=0x77, no stall. Required: slot 3 = 0x77. Repeat with stall[2]=1: slot 2 becomes 0x77, and 0x77 advances on the next free edge.
5. Update on bubble: upd_en on a slot with valid=0. Required: the next slot receives 0 / valid 0.
6. Async reset mid-stream: drop grst_n between edges. Required: all outputs 0 before the next clk edge, and buffer refill is correct after release.
